// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and types used by the register file.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int R0_IDX = 0;      // hardwired-zero register

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/register_bank.sv
// Register storage: two combinational read ports, one synchronous write port.
// Register 0 always reads as zero and ignores writes.
module register_bank
    import cpu_pkg::*;
#(
    parameter int                DATA_W    = cpu_pkg::DATA_W,
    parameter int                ADDR_W    = cpu_pkg::ADDR_W,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o
);

    localparam int NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] R0 = ADDR_W'(R0_IDX);

    logic [DATA_W-1:0] regs_q [NREG];

    // Storage update: reset loads RESET_VAL (R0 slot gets zero), writes to R0 are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= (i == R0_IDX) ? '0 : RESET_VAL;
        end else if (we_i && (waddr_i != R0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Read ports: address 0 is forced to zero regardless of storage contents.
    always_comb begin
        rdata_a_o = (raddr_a_i == R0) ? '0 : regs_q[raddr_a_i];
        rdata_b_o = (raddr_b_i == R0) ? '0 : regs_q[raddr_b_i];
    end

endmodule

// File: rtl/register_file.sv
// 8 x 16 register file with a one-entry write-back stage in front of the array.
// Optional macro REGFILE_BYPASS_EN: reads matching the pending write return its data.
module register_file
    import cpu_pkg::*;
#(
    parameter int                DATA_W    = cpu_pkg::DATA_W,
    parameter int                ADDR_W    = cpu_pkg::ADDR_W,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] AA,
    input  logic [ADDR_W-1:0] BA,
    input  logic [ADDR_W-1:0] DA,
    input  logic              RW,
    input  logic [DATA_W-1:0] D_data,
    input  logic              stall,
    output logic [DATA_W-1:0] A_data,
    output logic [DATA_W-1:0] B_data,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_addr
);

    logic              wb_valid_q, wb_valid_d;
    logic [ADDR_W-1:0] wb_addr_q,  wb_addr_d;
    logic [DATA_W-1:0] wb_data_q,  wb_data_d;
    logic [DATA_W-1:0] arr_a, arr_b;

    // Next write-back entry: a stalled request is dropped, data/address still sampled.
    always_comb begin
        wb_valid_d = RW & ~stall;
        wb_addr_d  = DA;
        wb_data_d  = D_data;
    end

    // Write-back stage register; reset discards any pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end

    // Commit of the staged write happens on the same edge as the next capture.
    register_bank #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .RESET_VAL (RESET_VAL)
    ) u_bank (
        .clk       (clk),
        .reset     (reset),
        .we_i      (wb_valid_q),
        .waddr_i   (wb_addr_q),
        .wdata_i   (wb_data_q),
        .raddr_a_i (AA),
        .raddr_b_i (BA),
        .rdata_a_o (arr_a),
        .rdata_b_o (arr_b)
    );

`ifdef REGFILE_BYPASS_EN
    localparam logic [ADDR_W-1:0] R0 = ADDR_W'(R0_IDX);

    // Forward the pending write to each read port independently; R0 is never forwarded.
    always_comb begin
        A_data = arr_a;
        B_data = arr_b;
        if (wb_valid_q && (wb_addr_q == AA) && (AA != R0)) A_data = wb_data_q;
        if (wb_valid_q && (wb_addr_q == BA) && (BA != R0)) B_data = wb_data_q;
    end
`else
    // Array contents only; the read-after-write hazard is left to the control unit.
    always_comb begin
        A_data = arr_a;
        B_data = arr_b;
    end
`endif

    assign wb_valid = wb_valid_q;
    assign wb_addr  = wb_addr_q;

endmodule
